// File: rtl/pc_sequencer_if.sv
// Fetch-request, hazard and branch-resolution signals of the PC sequencer.
// master: the sequencer; slave: the IF/EX/hazard side driving it.
interface pc_sequencer_if;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic        br_is_jalr;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic [31:0] br_rs1;
    logic        flush;
    logic        misalign_trap;

    modport master (
        input  fetch_ready, stall, br_valid, br_taken, br_is_jalr, br_pc, br_imm, br_rs1,
        output fetch_valid, fetch_pc, flush, misalign_trap
    );

    modport slave (
        output fetch_ready, stall, br_valid, br_taken, br_is_jalr, br_pc, br_imm, br_rs1,
        input  fetch_valid, fetch_pc, flush, misalign_trap
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner: sequential fetch, stall hold and branch/jump redirect with flush.
// Optional MISALIGN_TRAP_EN: misaligned targets redirect to TRAP_VECTOR and pulse misalign_trap.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef MISALIGN_TRAP_EN
    ,parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        HOLD     = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] fetch_pc_r, fetch_pc_nxt_s;
    logic        fetch_valid_r, fetch_valid_nxt_s;
    logic        flush_r, flush_nxt_s;
    logic        trap_r, trap_nxt_s;
    logic [31:0] target_r, target_nxt_s;
    logic [32:0] resolved_s;

    // Returns {misaligned, address}; the address is already the value fetch_pc must take.
    function automatic logic [32:0] resolve_target(
        input logic        is_jalr,
        input logic [31:0] pc,
        input logic [31:0] imm,
        input logic [31:0] rs1
    );
        logic [31:0] raw;
        logic [32:0] res;
        if (is_jalr) begin
            raw = (rs1 + imm) & ~32'h0000_0001;
        end else begin
            raw = pc + {imm[30:0], 1'b0};
        end
`ifdef MISALIGN_TRAP_EN
        if (raw[1:0] != 2'b00) begin
            res = {1'b1, TRAP_VECTOR};
        end else begin
            res = {1'b0, raw};
        end
`else
        res = {1'b0, raw[31:2], 2'b00};
`endif
        return res;
    endfunction

    // Target of the instruction EX presents this cycle.
    always_comb begin
        resolved_s = resolve_target(bus.br_is_jalr, bus.br_pc, bus.br_imm, bus.br_rs1);
    end

    // Next-state and next-output logic; redirect outranks stall, stall outranks advance.
    always_comb begin
        state_nxt_s       = state_r;
        fetch_pc_nxt_s    = fetch_pc_r;
        fetch_valid_nxt_s = fetch_valid_r;
        flush_nxt_s       = 1'b0;
        trap_nxt_s        = 1'b0;
        target_nxt_s      = target_r;
        case (state_r)
            BOOT: begin
                state_nxt_s       = RUN;
                fetch_valid_nxt_s = 1'b1;
            end
            RUN, HOLD: begin
                if (bus.br_valid && bus.br_taken) begin
                    state_nxt_s       = REDIRECT;
                    fetch_valid_nxt_s = 1'b0;
                    flush_nxt_s       = 1'b1;
                    trap_nxt_s        = resolved_s[32];
                    target_nxt_s      = resolved_s[31:0];
                end else if (bus.stall) begin
                    state_nxt_s       = HOLD;
                    fetch_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s       = RUN;
                    fetch_valid_nxt_s = 1'b1;
                    if (fetch_valid_r && bus.fetch_ready) begin
                        fetch_pc_nxt_s = fetch_pc_r + 32'd4;
                    end else begin
                        fetch_pc_nxt_s = fetch_pc_r;
                    end
                end
            end
            REDIRECT: begin
                // Branches seen here belong to flushed instructions and are ignored.
                fetch_pc_nxt_s = target_r;
                if (bus.stall) begin
                    state_nxt_s       = HOLD;
                    fetch_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s       = RUN;
                    fetch_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s       = BOOT;
                fetch_pc_nxt_s    = RESET_VECTOR;
                fetch_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= BOOT;
            fetch_pc_r    <= RESET_VECTOR;
            fetch_valid_r <= 1'b0;
            flush_r       <= 1'b0;
            trap_r        <= 1'b0;
            target_r      <= RESET_VECTOR;
        end else begin
            state_r       <= state_nxt_s;
            fetch_pc_r    <= fetch_pc_nxt_s;
            fetch_valid_r <= fetch_valid_nxt_s;
            flush_r       <= flush_nxt_s;
            trap_r        <= trap_nxt_s;
            target_r      <= target_nxt_s;
        end
    end

    assign bus.fetch_pc      = fetch_pc_r;
    assign bus.fetch_valid   = fetch_valid_r;
    assign bus.flush         = flush_r;
`ifdef MISALIGN_TRAP_EN
    assign bus.misalign_trap = trap_r;
`else
    assign bus.misalign_trap = 1'b0;
`endif

endmodule
